// File: rtl/complex_mac.sv
// Pipelined signed complex multiply-accumulate with valid/ready handshakes.
// Three stages: operand register, product register, accumulate/output.
module complex_mac #(
    parameter int WIDTH = 8,
    parameter int ACC_GUARD = 4,
    parameter int CNT_W = 8,
    localparam int OUT_W = 2*WIDTH+1+ACC_GUARD
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_real_i,
    input  logic [WIDTH-1:0] a_imag_i,
    input  logic [WIDTH-1:0] b_real_i,
    input  logic [WIDTH-1:0] b_imag_i,
    input  logic             conj_i,
    input  logic             last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] c_real_o,
    output logic [OUT_W-1:0] c_imag_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PW = 2*WIDTH;
    localparam int SW = PW+1;

    logic stall;
    logic adv;

    logic                    s1_valid, s1_conj, s1_last;
    logic signed [WIDTH-1:0] s1_ar, s1_ai, s1_br, s1_bi;

    logic                 s2_valid, s2_conj, s2_last;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;

    logic signed [SW-1:0]    smp_re, smp_im;
    logic signed [OUT_W-1:0] sum_re, sum_im;
    logic signed [OUT_W-1:0] acc_re, acc_im;
    logic [CNT_W-1:0]        cnt, cnt_next;

    // A held result freezes the whole pipe.
    assign stall      = out_valid_o & ~out_ready_i;
    assign adv        = ~stall;
    assign in_ready_o = adv;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_conj  <= 1'b0;
            s1_last  <= 1'b0;
            s1_ar    <= '0;
            s1_ai    <= '0;
            s1_br    <= '0;
            s1_bi    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid_i;
            s1_conj  <= conj_i;
            s1_last  <= last_i;
            s1_ar    <= a_real_i;
            s1_ai    <= a_imag_i;
            s1_br    <= b_real_i;
            s1_bi    <= b_imag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_conj  <= 1'b0;
            s2_last  <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ir     <= '0;
            p_ri     <= '0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_conj  <= s1_conj;
            s2_last  <= s1_last;
            p_rr     <= PW'(s1_ar) * PW'(s1_br);
            p_ii     <= PW'(s1_ai) * PW'(s1_bi);
            p_ir     <= PW'(s1_ai) * PW'(s1_br);
            p_ri     <= PW'(s1_ar) * PW'(s1_bi);
        end
    end

    always_comb begin
        smp_re = '0;
        smp_im = '0;
        if (s2_conj) begin
            smp_re = {p_rr[PW-1], p_rr} + {p_ii[PW-1], p_ii};
            smp_im = {p_ir[PW-1], p_ir} - {p_ri[PW-1], p_ri};
        end else begin
            smp_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
            smp_im = {p_ir[PW-1], p_ir} + {p_ri[PW-1], p_ri};
        end
        sum_re   = acc_re + {{(OUT_W-SW){smp_re[SW-1]}}, smp_re};
        sum_im   = acc_im + {{(OUT_W-SW){smp_im[SW-1]}}, smp_im};
        cnt_next = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_re      <= '0;
            acc_im      <= '0;
            cnt         <= '0;
            out_valid_o <= 1'b0;
            c_real_o    <= '0;
            c_imag_o    <= '0;
            count_o     <= '0;
        end else if (adv) begin
            out_valid_o <= s2_valid & s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    c_real_o <= sum_re;
                    c_imag_o <= sum_im;
                    count_o  <= cnt_next;
                    acc_re   <= '0;
                    acc_im   <= '0;
                    cnt      <= '0;
                end else begin
                    acc_re <= sum_re;
                    acc_im <= sum_im;
                    cnt    <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_complex_mac.sv
// Scoreboard bench for complex_mac: directed vectors, decoupled monitor.
module tb_complex_mac;

    localparam int WIDTH = 8;
    localparam int ACC_GUARD = 4;
    localparam int CNT_W = 8;
    localparam int OUT_W = 2*WIDTH+1+ACC_GUARD;

    logic             clk_i = 1'b0;
    logic             rst_n_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_real_i = '0;
    logic [WIDTH-1:0] a_imag_i = '0;
    logic [WIDTH-1:0] b_real_i = '0;
    logic [WIDTH-1:0] b_imag_i = '0;
    logic             conj_i = 1'b0;
    logic             last_i = 1'b0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [OUT_W-1:0] c_real_o;
    logic [OUT_W-1:0] c_imag_o;
    logic [CNT_W-1:0] count_o;

    typedef struct {
        longint re;
        longint im;
        int     cnt;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    complex_mac #(
        .WIDTH(WIDTH),
        .ACC_GUARD(ACC_GUARD),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o),
        .a_real_i(a_real_i),
        .a_imag_i(a_imag_i),
        .b_real_i(b_real_i),
        .b_imag_i(b_imag_i),
        .conj_i(conj_i),
        .last_i(last_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .c_real_o(c_real_o),
        .c_imag_o(c_imag_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sre();
        return longint'($signed(c_real_o));
    endfunction

    function automatic longint sim();
        return longint'($signed(c_imag_o));
    endfunction

    // Monitor: compare on transfer, check held data and ready while stalled.
    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (out_valid_o && !out_ready_i) begin
                check("in_ready_stall", longint'(in_ready_o), 0);
                if (sb.size() > 0) begin
                    check("held_re", sre(), sb[0].re);
                    check("held_im", sim(), sb[0].im);
                    check("held_cnt", longint'(count_o), longint'(sb[0].cnt));
                end
            end else begin
                check("in_ready_free", longint'(in_ready_o), 1);
            end
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("c_real", sre(), sb[0].re);
                    check("c_imag", sim(), sb[0].im);
                    check("count", longint'(count_o), longint'(sb[0].cnt));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send(input int ar, input int ai, input int br, input int bi,
                        input bit cj, input bit lst,
                        input longint ere, input longint eim, input int ecnt);
        bit acc;
        int guard;
        a_real_i   = WIDTH'(ar);
        a_imag_i   = WIDTH'(ai);
        b_real_i   = WIDTH'(br);
        b_imag_i   = WIDTH'(bi);
        conj_i     = cj;
        last_i     = lst;
        in_valid_i = 1'b1;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 100) begin
            @(negedge clk_i);
            acc = in_ready_o;
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (!acc) check("send_timeout", 0, 1);
        else if (lst) sb.push_back('{ere, eim, ecnt});
        in_valid_i = 1'b0;
        last_i     = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        check("drain_timeout", longint'(sb.size()), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", longint'(out_valid_o), 0);
        check("rst_c_real", sre(), 0);
        check("rst_c_imag", sim(), 0);
        check("rst_count", longint'(count_o), 0);
        check("rst_in_ready", longint'(in_ready_o), 1);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Single multiply with latency check.
        send(3, 4, 5, -2, 1'b0, 1'b1, 23, 14, 1);
        check("lat_k", longint'(out_valid_o), 0);
        @(posedge clk_i);
        #1;
        check("lat_k1", longint'(out_valid_o), 0);
        @(posedge clk_i);
        #1;
        check("lat_k2", longint'(out_valid_o), 1);
        drain();

        // Conjugate, then alternating back-to-back.
        send(3, 4, 5, -2, 1'b1, 1'b1, 7, 26, 1);
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) send(3, 4, 5, -2, 1'b0, 1'b1, 23, 14, 1);
            else            send(3, 4, 5, -2, 1'b1, 1'b1, 7, 26, 1);
        end
        drain();

        // Extremes: imaginary sum must not wrap.
        send(-128, -128, -128, -128, 1'b0, 1'b1, 0, 32768, 1);
        send(-128, -128, -128, -128, 1'b1, 1'b1, 32768, 0, 1);
        drain();

        // Accumulate four samples.
        for (int i = 0; i < 3; i++) send(1, 1, 1, 1, 1'b0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clk_i);
        #1;
        check("acc_no_output", longint'(out_valid_o), 0);
        send(1, 1, 1, 1, 1'b0, 1'b1, 0, 8, 4);
        drain();

        // Backpressure across a stream of single-sample bursts.
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(i + 1, 2, 3, -1, 1'b0, 1'b1, 3*i + 5, 5 - i, 1);
            end
            begin
                repeat (4) @(posedge clk_i);
                #1;
                out_ready_i = 1'b0;
                repeat (5) @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        drain();

        // Counter saturation over a long burst.
        for (int i = 0; i < 259; i++) send(1, 0, 1, 0, 1'b0, 1'b0, 0, 0, 0);
        send(1, 0, 1, 0, 1'b0, 1'b1, 260, 0, 255);
        drain();

        // Reset mid-burst discards the partial sum.
        send(10, 0, 1, 0, 1'b0, 1'b0, 0, 0, 0);
        send(10, 0, 1, 0, 1'b0, 1'b0, 0, 0, 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("arst_out_valid", longint'(out_valid_o), 0);
        check("arst_c_real", sre(), 0);
        check("arst_count", longint'(count_o), 0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        send(1, 0, 1, 0, 1'b0, 1'b1, 1, 0, 1);
        drain();

        repeat (3) @(posedge clk_i);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/complex_mac.md
# complex_mac

Pipelined signed complex multiply-accumulate unit with valid/ready handshakes at input and output. It generalises the team's four-multiplier complex multiplier in four ways: signed full-precision arithmetic, a per-sample conjugate mode, accumulation across a `last`-delimited burst (dot products and correlations), and backpressure. It sits in the DSP datapath between sample sources (FIFOs, NCO/mixer) and downstream filters or correlators. Bursts of length 1 make it a plain complex multiplier.

## Interface
- `WIDTH`, default 8: signed input component width.
- `ACC_GUARD`, default 4: guard bits added to the full-precision product width for accumulation.
- `CNT_W`, default 8: width of the burst sample counter.
- Derived `OUT_W` = 2*WIDTH+1+ACC_GUARD.

Ports:
- `clk_i`  in  1: single clock; all logic is on the rising edge.
- `rst_n_i`  in  1: reset, asynchronous, active-low.
- `in_valid_i`  in  1: input sample valid.
- `in_ready_o`  out  1: input can accept a sample.
- `a_real_i`, `a_imag_i`  in  WIDTH: operand a, signed two's complement.
- `b_real_i`, `b_imag_i`  in  WIDTH: operand b, signed.
- `conj_i`  in  1: when 1, use conj(b) for this sample.
- `last_i`  in  1: final sample of the burst.
- `out_valid_o`  out  1: result valid.
- `out_ready_i`  in  1: downstream accepts the result.
- `c_real_o`, `c_imag_o`  out  OUT_W: signed accumulated result.
- `count_o`  out  CNT_W: number of samples in the result, saturating at 2^CNT_W-1.

## Operation
- Transfer rules:
  - An input transfer occurs on an edge where `in_valid_i` and `in_ready_o` are both 1.
  - An output transfer occurs on an edge where `out_valid_o` and `out_ready_i` are both 1.
- Per-sample products, all signed, 2*WIDTH bits, sign-extended before summing:
  - conj_i=0: re = ar*br − ai*bi; im = ai*br + ar*bi.
  - conj_i=1: re = ar*br + ai*bi; im = ai*br − ar*bi.
  - Sums are 2*WIDTH+1 bits, then sign-extended to OUT_W.
- Stage 1 registers the operands, `conj`, `last` and a valid bit.
- Stage 2 registers the four products plus `conj`, `last` and valid.
- Stage 3 (accumulate/output) runs when stage 2 is valid and the pipe is not stalled:
  - sum = acc + sample; cnt_next = sat(cnt+1).
  - If `last`: load `c_*_o` = sum, `count_o` = cnt_next, set `out_valid_o`=1, clear acc and cnt to 0.
  - Otherwise: acc = sum, cnt = cnt_next; the output register is untouched.
- Accumulator overflow wraps modulo 2^OUT_W. There is no saturation and no flag; ACC_GUARD sizes bursts of up to 2^ACC_GUARD samples at worst-case magnitude.
- Stall:
  - stall = `out_valid_o` & ~`out_ready_i`. A stall freezes every stage: registers, accumulator, counter and valids.
  - `in_ready_o` = ~stall. This is a combinational path from `out_ready_i`, which is permitted.
- `out_valid_o` drops to 0 after an output transfer unless a new `last` result is loaded on the same edge. In that case it stays 1 with the new data (back-to-back results).
- No `last` sample in flight means no output; partial sums persist indefinitely.
- Reset clears all valids, acc, cnt and outputs.
  - A burst in progress is discarded.
  - Samples after reset start a new burst.

## Timing
- Reset values: `out_valid_o`=0, `c_real_o`=0, `c_imag_o`=0, `count_o`=0. `in_ready_o`=1, since it is not stalled.
- Latency: a `last` sample accepted at edge k, with no stall, sets `out_valid_o` after edge k+2. Results are visible 2 cycles after acceptance.
- Throughput: 1 sample/cycle while `out_ready_i`=1.
- A stalled result holds `c_*_o` and `count_o` stable until it is transferred.
- Results leave in input order; no sample is dropped or duplicated under any `out_ready_i` pattern.
- Asynchronous reset takes effect immediately and does not wait for a clock edge. Release is synchronised externally.

## Test plan
- Single multiply, WIDTH=8: (3+4j)·(5−2j), conj=0, last=1 → c=23+14j, count=1, out_valid 2 cycles after acceptance.
- Conjugate: the same operands with conj=1 → c=7+26j. Alternate conj each cycle with last=1 → results alternate 23+14j / 7+26j back-to-back.
- Extremes: (−128−128j)·(−128−128j), last=1 → c=0+32768j; the imaginary part must not wrap. With conj=1 → c=32768+0j.
- Accumulate: 4 samples of (1+1j)·(1+1j), last on the 4th → one output, c=0+8j, count=4. No output for the first three.
- Backpressure: stream 10 single-sample bursts with `out_ready_i` low for 5 cycles mid-stream → `in_ready_o` low while the output is held, data frozen, all 10 results delivered in order.
- Reset mid-burst: 2 non-last samples of 10+0j, assert `rst_n_i` low → outputs 0 immediately. After release, one sample of 1+0j with last=1 → c=1+0j, count=1.
